// File: rtl/pedal_pkg.sv
// Shared types and reset defaults for the pedal parameter blocks.
// Also holds small byte helpers used by the tremolo parameter scheduler.
package pedal_pkg;

    typedef enum logic [1:0] {ADDR_RATE, ADDR_DEPTH, ADDR_DUTY, ADDR_EN} trem_addr_e;
    typedef enum logic [1:0] {IDLE, ARMED, COMMIT, RAMP} trem_state_e;

    localparam logic [7:0] RATE_RST_DEF   = 8'd16;
    localparam logic [7:0] DUTY_RST_DEF   = 8'd128;
    localparam logic [7:0] DUTY_MIN_DEF   = 8'd8;
    localparam logic [7:0] DUTY_MAX_DEF   = 8'd248;
    localparam logic [7:0] DEPTH_STEP_DEF = 8'd4;

    function automatic logic [7:0] clamp_u8(input logic [7:0] v, input logic [7:0] lo,
                                            input logic [7:0] hi);
        if (v < lo) return lo;
        if (v > hi) return hi;
        return v;
    endfunction

    // One slew step toward tgt, landing exactly on tgt when closer than step.
    function automatic logic [7:0] slew_step(input logic [7:0] cur, input logic [7:0] tgt,
                                             input logic [7:0] step);
        if (cur < tgt) return ((tgt - cur) > step) ? cur + step : tgt;
        if (cur > tgt) return ((cur - tgt) > step) ? cur - step : tgt;
        return cur;
    endfunction

endpackage

// File: rtl/lrck_edge_sync.sv
// Two-flop synchroniser for an asynchronous frame clock plus rising-edge detect.
// o_tick is a registered one-cycle pulse on the 3rd clk edge after i_lrck rises.
module lrck_edge_sync (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_lrck,
    output logic o_tick
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
            o_tick <= 1'b0;
        end else begin
            r_meta <= i_lrck;
            r_sync <= r_meta;
            r_prev <= r_sync;
            o_tick <= r_sync & ~r_prev;
        end
    end

endmodule

// File: rtl/trem_param_ctrl.sv
// Tremolo parameter scheduler: stages byte writes in shadows, commits on Lrck frame edges.
// Optional macro TREM_SLEW_EN makes Depth slew toward its committed target per frame.
module trem_param_ctrl
    import pedal_pkg::*;
#(
`ifdef TREM_SLEW_EN
    parameter logic [7:0] DEPTH_STEP = DEPTH_STEP_DEF,
`endif
    parameter logic [7:0] RATE_RST = RATE_RST_DEF,
    parameter logic [7:0] DUTY_RST = DUTY_RST_DEF,
    parameter logic [7:0] DUTY_MIN = DUTY_MIN_DEF,
    parameter logic [7:0] DUTY_MAX = DUTY_MAX_DEF
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Lrck,
    input  logic       Wr_Valid,
    output logic       Wr_Ready,
    input  logic [1:0] Wr_Addr,
    input  logic [7:0] Wr_Data,
    output logic       Enable,
    output logic [7:0] Rate,
    output logic [7:0] Depth,
    output logic [7:0] Duty_Cycle,
    output logic       Frame_Tick,
    output logic       Busy
);

    trem_state_e r_state;
    logic [7:0]  r_sh [4];
    logic [3:0]  r_dirty;

    logic        w_tick;
    logic        w_accept;
    logic [7:0]  w_wnorm;
    logic [3:0]  w_dirty_set;

    lrck_edge_sync u_lrck_sync (
        .i_clk  (Clk),
        .i_rst  (Reset),
        .i_lrck (Lrck),
        .o_tick (w_tick)
    );

    assign Frame_Tick = w_tick;
    assign Wr_Ready   = (r_state != COMMIT);
    assign Busy       = (r_state != IDLE);

    always_comb begin
        w_accept    = Wr_Valid && (r_state != COMMIT);
        w_dirty_set = w_accept ? (4'b0001 << Wr_Addr) : 4'b0000;
        unique case (trem_addr_e'(Wr_Addr))
            ADDR_RATE: w_wnorm = (Wr_Data == 8'd0) ? 8'd1 : Wr_Data;
            ADDR_DUTY: w_wnorm = clamp_u8(Wr_Data, DUTY_MIN, DUTY_MAX);
            ADDR_EN:   w_wnorm = {7'd0, Wr_Data[0]};
            default:   w_wnorm = Wr_Data;
        endcase
    end

`ifdef TREM_SLEW_EN
    logic [7:0] r_target;
    logic [7:0] w_tgt;
    logic [7:0] w_depth_next;

    // A Depth write pending at a ramp tick retargets the step taken on that same tick.
    always_comb begin
        w_tgt        = r_dirty[ADDR_DEPTH] ? r_sh[ADDR_DEPTH] : r_target;
        w_depth_next = slew_step(Depth, w_tgt, DEPTH_STEP);
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_state    <= IDLE;
            r_dirty    <= 4'b0000;
            for (int i = 0; i < 4; i++) r_sh[i] <= 8'd0;
            Enable     <= 1'b0;
            Rate       <= RATE_RST;
            Depth      <= 8'd0;
            Duty_Cycle <= DUTY_RST;
`ifdef TREM_SLEW_EN
            r_target   <= 8'd0;
`endif
        end else begin
            if (w_accept) r_sh[Wr_Addr] <= w_wnorm;
            r_dirty <= r_dirty | w_dirty_set;

            unique case (r_state)
                IDLE: begin
                    if (w_accept) r_state <= ARMED;
                end
                ARMED: begin
                    if (w_tick) r_state <= COMMIT;
                end
                COMMIT: begin
                    if (r_dirty[ADDR_RATE]) Rate       <= r_sh[ADDR_RATE];
                    if (r_dirty[ADDR_DUTY]) Duty_Cycle <= r_sh[ADDR_DUTY];
                    if (r_dirty[ADDR_EN])   Enable     <= r_sh[ADDR_EN][0];
                    r_dirty <= 4'b0000;
`ifdef TREM_SLEW_EN
                    if (r_dirty[ADDR_DEPTH]) r_target <= r_sh[ADDR_DEPTH];
                    r_state <= (r_dirty[ADDR_DEPTH] && (r_sh[ADDR_DEPTH] != Depth)) ? RAMP : IDLE;
`else
                    if (r_dirty[ADDR_DEPTH]) Depth <= r_sh[ADDR_DEPTH];
                    r_state <= IDLE;
`endif
                end
`ifdef TREM_SLEW_EN
                RAMP: begin
                    if (w_tick) begin
                        if (r_dirty[ADDR_RATE]) Rate       <= r_sh[ADDR_RATE];
                        if (r_dirty[ADDR_DUTY]) Duty_Cycle <= r_sh[ADDR_DUTY];
                        if (r_dirty[ADDR_EN])   Enable     <= r_sh[ADDR_EN][0];
                        r_dirty  <= w_dirty_set;
                        r_target <= w_tgt;
                        Depth    <= w_depth_next;
                        if (w_depth_next == w_tgt) r_state <= w_accept ? ARMED : IDLE;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_trem_param_ctrl.sv
// Self-checking bench for trem_param_ctrl: directed frame scenarios plus random write bursts
// checked against a transaction-level model of shadows, frame commits and optional slew.
module tb_trem_param_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       lrck;
    logic       wr_valid;
    logic       wr_ready;
    logic [1:0] wr_addr;
    logic [7:0] wr_data;
    logic       en_o;
    logic [7:0] rate_o;
    logic [7:0] depth_o;
    logic [7:0] duty_o;
    logic       tick_o;
    logic       busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    int tick_cnt = 0;

    // Model state: staged values, dirty flags, committed outputs, slew target.
    int m_sh [4];
    bit m_dirty [4];
    int m_en, m_rate, m_depth, m_duty, m_target;
    bit m_ramp;

    trem_param_ctrl dut (
        .Clk        (clk),
        .Reset      (rst),
        .Lrck       (lrck),
        .Wr_Valid   (wr_valid),
        .Wr_Ready   (wr_ready),
        .Wr_Addr    (wr_addr),
        .Wr_Data    (wr_data),
        .Enable     (en_o),
        .Rate       (rate_o),
        .Depth      (depth_o),
        .Duty_Cycle (duty_o),
        .Frame_Tick (tick_o),
        .Busy       (busy_o)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (tick_o) tick_cnt++;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            m_sh[i]    = 0;
            m_dirty[i] = 0;
        end
        m_en = 0; m_rate = 16; m_depth = 0; m_duty = 128; m_target = 0; m_ramp = 0;
    endfunction

    function automatic void model_write(input int a, input int d);
        int v;
        v = d;
        if (a == 0 && d == 0) v = 1;
        if (a == 2) v = (d < 8) ? 8 : ((d > 248) ? 248 : d);
        if (a == 3) v = d % 2;
        m_sh[a]    = v;
        m_dirty[a] = 1;
    endfunction

    function automatic bit model_any_dirty();
        return m_dirty[0] || m_dirty[1] || m_dirty[2] || m_dirty[3];
    endfunction

    function automatic void model_commit_others();
        if (m_dirty[0]) m_rate = m_sh[0];
        if (m_dirty[2]) m_duty = m_sh[2];
        if (m_dirty[3]) m_en   = m_sh[3];
    endfunction

    // Effect of one frame edge on the committed outputs.
    function automatic void model_frame();
        if (m_ramp) begin
            if (m_dirty[1]) m_target = m_sh[1];
            model_commit_others();
            if (m_target > m_depth)
                m_depth = (m_target - m_depth > 4) ? m_depth + 4 : m_target;
            else if (m_target < m_depth)
                m_depth = (m_depth - m_target > 4) ? m_depth - 4 : m_target;
            if (m_depth == m_target) m_ramp = 0;
        end else if (model_any_dirty()) begin
            model_commit_others();
            if (m_dirty[1]) begin
`ifdef TREM_SLEW_EN
                m_target = m_sh[1];
                m_ramp   = (m_target != m_depth);
`else
                m_depth  = m_sh[1];
`endif
            end
        end
        for (int i = 0; i < 4; i++) m_dirty[i] = 0;
    endfunction

    task automatic check_outputs(input string tag);
        check_eq({tag, ".en"},    en_o,    m_en);
        check_eq({tag, ".rate"},  rate_o,  m_rate);
        check_eq({tag, ".depth"}, depth_o, m_depth);
        check_eq({tag, ".duty"},  duty_o,  m_duty);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycle();
        cycle();
        rst = 1'b0;
        model_reset();
        cycle();
        check_outputs("reset");
        check_eq("reset.busy",  busy_o,   0);
        check_eq("reset.ready", wr_ready, 1);
        check_eq("reset.tick",  tick_o,   0);
    endtask

    task automatic write(input int a, input int d);
        wr_valid = 1'b1;
        wr_addr  = a[1:0];
        wr_data  = d[7:0];
        check_eq("wr.ready", wr_ready, 1);
        cycle();
        model_write(a, d);
        wr_valid = 1'b0;
    endtask

    // Raise Lrck just after a falling edge, then walk the five edges to the committed result.
    task automatic frame(input bit chk_latency);
        bit exp_commit;
        lrck = 1'b1;
        exp_commit = model_any_dirty() && !m_ramp;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            if (k == 3) check_eq("frame.tick", tick_o, 1);
            if (k == 4) begin
                check_eq("frame.tick_width", tick_o, 0);
                check_eq("frame.commit_ready", wr_ready, exp_commit ? 0 : 1);
                if (chk_latency) check_eq("frame.rate_before_commit", rate_o, m_rate);
                model_frame();
            end
        end
        check_outputs("frame");
        check_eq("frame.busy", busy_o, m_ramp);
        lrck = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
    endtask

    task automatic settle();
        for (int n = 0; n < 80 && m_ramp; n++) frame(1'b0);
    endtask

    initial begin
        int t0;
        rst      = 1'b1;
        lrck     = 1'b0;
        wr_valid = 1'b0;
        wr_addr  = 2'd0;
        wr_data  = 8'd0;
        cycle();
        do_reset();

        // Idle frames leave everything at reset values.
        t0 = tick_cnt;
        for (int i = 0; i < 5; i++) frame(1'b0);
        check_eq("idle.tick_count", tick_cnt - t0, 5);

        // Rate write mid-frame, with commit latency checked.
        write(0, 8'h40);
        check_eq("rate.busy_armed", busy_o, 1);
        check_eq("rate.hold", rate_o, 16);
        frame(1'b1);

        // Last Depth write before the edge wins.
        write(1, 8'h10);
        write(1, 8'h90);
        frame(1'b0);
        settle();

        // Write held through COMMIT is accepted on the following cycle.
        write(0, 8'h22);
        lrck = 1'b1;
        cycle(); cycle(); cycle();
        check_eq("hold.tick", tick_o, 1);
        cycle();
        check_eq("hold.commit_ready", wr_ready, 0);
        wr_valid = 1'b1;
        wr_addr  = 2'd0;
        wr_data  = 8'h00;
        model_frame();
        cycle();
        check_outputs("hold.commit");
        check_eq("hold.busy_after", busy_o, 0);
        check_eq("hold.ready_after", wr_ready, 1);
        cycle();
        model_write(0, 0);
        wr_valid = 1'b0;
        check_eq("hold.busy_rearmed", busy_o, 1);
        check_eq("hold.rate_kept", rate_o, 8'h22);
        lrck = 1'b0;
        for (int k = 0; k < 4; k++) cycle();
        frame(1'b0);
        check_eq("hold.rate_one", rate_o, 1);

        // Duty clamps at both ends, then Enable uses bit 0 only.
        write(2, 8'h02);
        frame(1'b0);
        check_eq("duty.low", duty_o, 8);
        write(2, 8'hFF);
        frame(1'b0);
        check_eq("duty.high", duty_o, 248);
        write(3, 8'h03);
        frame(1'b0);

        // Random write bursts between frames.
        for (int it = 0; it < 15; it++) begin
            int nw;
            nw = $urandom_range(1, 5);
            for (int w = 0; w < nw; w++) begin
                int a, d;
                a = $urandom_range(0, 3);
                case ($urandom_range(0, 3))
                    0:       d = 0;
                    1:       d = $urandom_range(0, 9);
                    2:       d = $urandom_range(245, 255);
                    default: d = $urandom_range(0, 255);
                endcase
                write(a, d);
            end
            check_outputs("rand.hold");
            check_eq("rand.busy", busy_o, 1);
            frame(1'b0);
        end
        settle();

        // Depth 0 -> 0x0A (slews 4, 8, 10 when enabled), then reset mid-move.
        write(1, 0);
        frame(1'b0);
        settle();
        write(1, 8'h0A);
        for (int i = 0; i < 4; i++) frame(1'b0);
        check_eq("depth.final", depth_o, 8'h0A);
        write(1, 8'hC0);
        frame(1'b0);
        frame(1'b0);
        do_reset();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
